alu_apb_master: RTL and testbench
=================================

Name: alu_apb_master

Overview:
- APB initiator that drives the ALU subsystem's CSR slave port from a simple valid/ready command stream.
- Per command: writes operand 0, operand 1, then the control word (which pushes the job into the ALU input FIFO).
- Independently polls status and pops results, returning each on a valid/ready response stream.
- Sits between a host/test sequencer and the ALU top's APB port.

Parameters:
- DATA_SIZE, 16, operand/result width
- ID_SIZE, 8, job tag width
- OPERATION_SIZE, 2, opcode width
- OPERATION_BIT, 1, opcode LSB in control word
- ID_BIT, 8, id LSB in control word
- APB_BUS_SIZE, 32, APB data width
- ADDRESS_SIZE, 3, APB address width
- REG_CTRL/REG_0/REG_1/REG_RES/REG_STATUS, 0/1/2/3/4, CSR addresses
- STAT_FULL_IN_BIT, 0, status bit: input FIFO full
- STAT_EMPTY_OUT_BIT, 1, status bit: output FIFO empty
- MAX_OUTSTANDING, 8, max issued-but-unread jobs

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle
- cmd_op  in  OPERATION_SIZE  opcode (1=add, 2=mul)
- cmd_id  in  ID_SIZE  job tag
- cmd_data0  in  DATA_SIZE  operand 0
- cmd_data1  in  DATA_SIZE  operand 1
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_result  out  DATA_SIZE  ALU result
- rsp_flag  out  1  carry/overflow bit (rdata[DATA_SIZE])
- rsp_id  out  ID_SIZE  tag (rdata[DATA_SIZE+1 +: ID_SIZE])
- rsp_err  out  1  APB slv_err seen on this job/read
- sel, en, write  out  1 each  APB control
- addr  out  ADDRESS_SIZE  APB address
- wdata  out  APB_BUS_SIZE  APB write data
- ready, slv_err  in  1 each  APB completion and error
- rdata  in  APB_BUS_SIZE  APB read data

Behaviour:
- Reset: all outputs 0, FSM in IDLE, outstanding count 0, priority flag = issue.
- Every APB transfer: one SETUP cycle (sel=1, en=0), then ACCESS (sel=1, en=1) held until ready=1. addr/write/wdata are stable across both phases. slv_err is sampled only when ready=1. Back-to-back transfers are allowed (next SETUP in the cycle after ready); sel drops only in IDLE/RSP.
- cmd_ready=1 only in IDLE when the issue branch is chosen. The command is latched in a skid-free register on handshake.
- IDLE arbitration:
  - issue eligible = cmd_valid && count<MAX_OUTSTANDING.
  - drain eligible = count>0.
  - Both eligible: round-robin flag picks, then toggles.
- Issue path: CHK_IN (read REG_STATUS) → stay in CHK_IN while STAT_FULL_IN_BIT=1 → WR_D0 (REG_0, wdata zero-extended data0) → WR_D1 (REG_1) → WR_CTRL (REG_CTRL, op at OPERATION_BIT, id at ID_BIT, other bits 0) → count+1 → IDLE.
- slv_err on any issue transfer: abort remaining writes, count unchanged, go to RSP with rsp_err=1, rsp_id=cmd_id, result 0.
- Drain path: POLL (read REG_STATUS) → IDLE if STAT_EMPTY_OUT_BIT=1 (re-arbitrate) → else RD_RES (read REG_RES) → count−1 → RSP with fields unpacked from rdata. rsp_err=slv_err of the RD_RES transfer (count still decremented).
- RSP: rsp_valid=1, fields held stable until rsp_ready; on handshake go to IDLE. No APB activity while in RSP.
- count never wraps: issue is blocked at MAX_OUTSTANDING; drain is not attempted at 0.
- Reset mid-transfer: sel/en drop immediately (asynchronous), and pending command and count are discarded.

Decomposition:
- Package alu_apb_pkg: CSR address constants, status bit indices, opcode constants OP_ADD=1 / OP_MUL=2, FSM state enum (IDLE, CHK_IN, WR_D0, WR_D1, WR_CTRL, POLL, RD_RES, RSP).
- One sub-module, apb_xfer_phase: SETUP/ACCESS sequencing. Takes start/addr/write/wdata; returns done/err/rdata. The top FSM only sequences registers.

Test Plan:
- Single add: cmd op=1 id=0x11 d0=0x0005 d1=0x0003, slave ready immediately → APB writes REG_0=5, REG_1=3, REG_CTRL=0x1102; rsp result=0x0008 flag=0 id=0x11 err=0.
- Mul with wait states (ready low 3 cycles each): op=2 id=0x22 d0=0x0F d1=0x0F → en held 4 cycles per access, addr stable; rsp result=0x00E1 id=0x22.
- Input FIFO full: status returns full_in=1 for 5 reads → no REG_0 write until it clears, and cmd_ready stays 0 after acceptance.
- Error: slv_err on REG_1 write, id=0x33 → no REG_CTRL write; rsp err=1 id=0x33 result=0; count unchanged.
- Backpressure/limit: MAX_OUTSTANDING=2, results withheld (empty_out=1) → third cmd_ready stays 0. Release results → ids returned in order; rsp fields stable while rsp_ready=0.
- rst_n asserted during ACCESS → sel=en=0 in the same cycle; post-reset count=0 and the first transfer is a fresh SETUP.

Source files
------------

// File: rtl/alu_apb_pkg.sv
// Shared constants, CSR map and FSM types for the ALU APB initiator.
// Widths follow the ALU subsystem CSR slave port.
package alu_apb_pkg;

  localparam int DATA_SIZE      = 16;
  localparam int ID_SIZE        = 8;
  localparam int OPERATION_SIZE = 2;
  localparam int OPERATION_BIT  = 1;
  localparam int ID_BIT         = 8;
  localparam int APB_BUS_SIZE   = 32;
  localparam int ADDRESS_SIZE   = 3;

  localparam int STAT_FULL_IN_BIT   = 0;
  localparam int STAT_EMPTY_OUT_BIT = 1;
  localparam int MAX_OUTSTANDING_DFLT = 8;

  localparam logic [ADDRESS_SIZE-1:0] REG_CTRL   = 3'd0;
  localparam logic [ADDRESS_SIZE-1:0] REG_0      = 3'd1;
  localparam logic [ADDRESS_SIZE-1:0] REG_1      = 3'd2;
  localparam logic [ADDRESS_SIZE-1:0] REG_RES    = 3'd3;
  localparam logic [ADDRESS_SIZE-1:0] REG_STATUS = 3'd4;

  localparam logic [OPERATION_SIZE-1:0] OP_ADD = 2'd1;
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = 2'd2;

  typedef enum logic [2:0] {
    IDLE, CHK_IN, WR_D0, WR_D1,
    WR_CTRL, POLL, RD_RES, RSP
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE, PH_SETUP, PH_ACCESS
  } phase_t;

  typedef struct packed {
    logic [OPERATION_SIZE-1:0] op;
    logic [ID_SIZE-1:0]        id;
    logic [DATA_SIZE-1:0]      d0;
    logic [DATA_SIZE-1:0]      d1;
  } cmd_t;

  function automatic logic [APB_BUS_SIZE-1:0] ctrl_word(
    input logic [OPERATION_SIZE-1:0] op,
    input logic [ID_SIZE-1:0]        id
  );
    logic [APB_BUS_SIZE-1:0] w;
    w = '0;
    w[OPERATION_BIT +: OPERATION_SIZE] = op;
    w[ID_BIT +: ID_SIZE] = id;
    return w;
  endfunction

  function automatic logic is_xfer(input state_t s);
    return s inside {CHK_IN, WR_D0, WR_D1,
                     WR_CTRL, POLL, RD_RES};
  endfunction

endpackage

// File: rtl/apb_xfer_phase.sv
// APB SETUP/ACCESS sequencer for one transfer at a time.
// A start on the completing cycle chains the next SETUP back-to-back.
module apb_xfer_phase
  import alu_apb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDRESS_SIZE-1:0] xfer_addr,
  input  logic                    xfer_write,
  input  logic [APB_BUS_SIZE-1:0] xfer_wdata,
  output logic                    done,
  output logic                    err,
  output logic [APB_BUS_SIZE-1:0] xfer_rdata,
  output logic                    sel,
  output logic                    en,
  output logic                    write,
  output logic [ADDRESS_SIZE-1:0] addr,
  output logic [APB_BUS_SIZE-1:0] wdata,
  input  logic                    ready,
  input  logic                    slv_err,
  input  logic [APB_BUS_SIZE-1:0] rdata
);

  phase_t phase, phase_nx;
  logic   load;

  assign sel        = phase != PH_IDLE;
  assign en         = phase == PH_ACCESS;
  assign done       = en && ready;
  assign err        = done && slv_err;
  assign xfer_rdata = rdata;
  assign load       = start && (phase == PH_IDLE || done);

  always_comb begin
    phase_nx = phase;
    unique case (phase)
      PH_IDLE:   if (start) phase_nx = PH_SETUP;
      PH_SETUP:  phase_nx = PH_ACCESS;
      PH_ACCESS: if (ready)
                   phase_nx = start ? PH_SETUP : PH_IDLE;
      default:   phase_nx = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_IDLE;
      addr  <= '0;
      write <= 1'b0;
      wdata <= '0;
    end else begin
      phase <= phase_nx;
      if (load) begin
        addr  <= xfer_addr;
        write <= xfer_write;
        wdata <= xfer_wdata;
      end
    end
  end

endmodule

// File: rtl/alu_apb_master.sv
// APB initiator feeding the ALU CSR port from a command stream
// and draining results onto a response stream.
module alu_apb_master
  import alu_apb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DFLT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [OPERATION_SIZE-1:0] cmd_op,
  input  logic [ID_SIZE-1:0]        cmd_id,
  input  logic [DATA_SIZE-1:0]      cmd_data0,
  input  logic [DATA_SIZE-1:0]      cmd_data1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_SIZE-1:0]      rsp_result,
  output logic                      rsp_flag,
  output logic [ID_SIZE-1:0]        rsp_id,
  output logic                      rsp_err,
  output logic                      sel,
  output logic                      en,
  output logic                      write,
  output logic [ADDRESS_SIZE-1:0]   addr,
  output logic [APB_BUS_SIZE-1:0]   wdata,
  input  logic                      ready,
  input  logic                      slv_err,
  input  logic [APB_BUS_SIZE-1:0]   rdata
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  state_t                  state, state_nx;
  cmd_t                    cmd_q;
  logic [CW-1:0]           count;
  logic                    prio_issue;
  logic                    issue_ok, drain_ok;
  logic                    pick_issue, pick_drain;
  logic                    inc, dec, abort, take;
  logic                    start, done, err;
  logic [ADDRESS_SIZE-1:0] xaddr;
  logic                    xwrite;
  logic [APB_BUS_SIZE-1:0] xwdata, xrdata;
  logic                    unused_rdata;

  assign unused_rdata =
    ^xrdata[APB_BUS_SIZE-1:DATA_SIZE+1+ID_SIZE];

  assign issue_ok   = cmd_valid &&
                      (count < CW'(MAX_OUTSTANDING));
  assign drain_ok   = count != '0;
  assign pick_issue = issue_ok && (!drain_ok || prio_issue);
  assign pick_drain = drain_ok && (!issue_ok || !prio_issue);
  assign cmd_ready  = (state == IDLE) && pick_issue;
  assign rsp_valid  = state == RSP;

  always_comb begin
    state_nx = state;
    inc      = 1'b0;
    dec      = 1'b0;
    abort    = 1'b0;
    take     = 1'b0;
    unique case (state)
      IDLE:
        if (pick_issue)      state_nx = CHK_IN;
        else if (pick_drain) state_nx = POLL;
      CHK_IN:
        if (err) begin
          state_nx = RSP;
          abort    = 1'b1;
        end else if (done && !xrdata[STAT_FULL_IN_BIT])
          state_nx = WR_D0;
      WR_D0:
        if (err) begin
          state_nx = RSP;
          abort    = 1'b1;
        end else if (done) state_nx = WR_D1;
      WR_D1:
        if (err) begin
          state_nx = RSP;
          abort    = 1'b1;
        end else if (done) state_nx = WR_CTRL;
      WR_CTRL:
        if (err) begin
          state_nx = RSP;
          abort    = 1'b1;
        end else if (done) begin
          state_nx = IDLE;
          inc      = 1'b1;
        end
      POLL:
        if (done)
          state_nx = (err || xrdata[STAT_EMPTY_OUT_BIT])
                     ? IDLE : RD_RES;
      RD_RES:
        if (done) begin
          state_nx = RSP;
          dec      = 1'b1;
          take     = 1'b1;
        end
      RSP:     if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request for the transfer the FSM is about to enter.
  always_comb begin
    xaddr  = REG_STATUS;
    xwrite = 1'b0;
    xwdata = '0;
    unique case (state_nx)
      WR_D0: begin
        xaddr  = REG_0;
        xwrite = 1'b1;
        xwdata = APB_BUS_SIZE'(cmd_q.d0);
      end
      WR_D1: begin
        xaddr  = REG_1;
        xwrite = 1'b1;
        xwdata = APB_BUS_SIZE'(cmd_q.d1);
      end
      WR_CTRL: begin
        xaddr  = REG_CTRL;
        xwrite = 1'b1;
        xwdata = ctrl_word(cmd_q.op, cmd_q.id);
      end
      RD_RES:  xaddr = REG_RES;
      default: xaddr = REG_STATUS;
    endcase
  end

  assign start = is_xfer(state_nx) &&
                 (!is_xfer(state) || done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      prio_issue <= 1'b1;
      cmd_q      <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (cmd_ready)
        cmd_q <= {cmd_op, cmd_id, cmd_data0, cmd_data1};
      if (state == IDLE && issue_ok && drain_ok)
        prio_issue <= !prio_issue;
      if (inc)      count <= count + 1'b1;
      else if (dec) count <= count - 1'b1;
      if (abort) begin
        rsp_result <= '0;
        rsp_flag   <= 1'b0;
        rsp_id     <= cmd_q.id;
        rsp_err    <= 1'b1;
      end else if (take) begin
        rsp_result <= xrdata[DATA_SIZE-1:0];
        rsp_flag   <= xrdata[DATA_SIZE];
        rsp_id     <= xrdata[DATA_SIZE+1 +: ID_SIZE];
        rsp_err    <= err;
      end
    end
  end

  apb_xfer_phase u_xfer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .xfer_addr  (xaddr),
    .xfer_write (xwrite),
    .xfer_wdata (xwdata),
    .done       (done),
    .err        (err),
    .xfer_rdata (xrdata),
    .sel        (sel),
    .en         (en),
    .write      (write),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .slv_err    (slv_err),
    .rdata      (rdata)
  );

endmodule

// File: tb/tb_alu_apb_master.sv
// Directed bench for alu_apb_master with a behavioural ALU CSR slave.
// Outstanding limit is set to 2 to reach the back-pressure boundary.
module tb_alu_apb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [7:0]  cmd_id = '0;
  logic [15:0] cmd_data0 = '0;
  logic [15:0] cmd_data1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_flag;
  logic [7:0]  rsp_id;
  logic        rsp_err;
  logic        sel, en, write;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        ready, slv_err;
  logic [31:0] rdata;

  int ncmp = 0;
  int nfail = 0;

  // slave configuration (driven by the stimulus)
  int       wait_cfg = 0;
  int       full_req = 0;
  bit       hold_results = 1'b0;
  bit       err_on = 1'b0;
  logic [2:0] err_addr = 3'd2;

  // slave state
  int          wait_cnt = 0;
  int          full_used = 0;
  logic [31:0] res_mem [16];
  int          res_wp = 0;
  int          res_rp = 0;
  logic [15:0] m_d0 = '0;
  logic [15:0] m_d1 = '0;

  // transfer log
  logic [2:0]  lg_addr [$];
  logic        lg_wr [$];
  logic [31:0] lg_data [$];
  int          lg_en [$];
  bit          lg_ok [$];
  int          en_cnt = 0;
  bit          setup_seen = 0;
  bit          unstable = 0;
  logic [2:0]  cap_addr;
  logic        cap_wr;
  logic [31:0] cap_data;

  alu_apb_master #(.MAX_OUTSTANDING(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_id     (cmd_id),
    .cmd_data0  (cmd_data0),
    .cmd_data1  (cmd_data1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .sel        (sel),
    .en         (en),
    .write      (write),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .slv_err    (slv_err),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  assign ready   = sel && en && (wait_cnt >= wait_cfg);
  assign slv_err = ready && err_on && write &&
                   (addr == err_addr);

  always_comb begin
    rdata = '0;
    if (addr == 3'd4)
      rdata = {30'd0, hold_results || (res_wp == res_rp),
               full_used < full_req};
    else if (addr == 3'd3 && res_wp != res_rp)
      rdata = res_mem[res_rp[3:0]];
  end

  function automatic logic [31:0] alu_calc(input logic [31:0] c);
    logic [16:0] s;
    logic [31:0] p;
    s = {1'b0, m_d0} + {1'b0, m_d1};
    p = {16'd0, m_d0} * {16'd0, m_d1};
    if (c[2:1] == 2'd2)
      return {7'd0, c[15:8], |p[31:16], p[15:0]};
    return {7'd0, c[15:8], s[16], s[15:0]};
  endfunction

  always @(posedge clk) begin
    if (sel && en && !ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (!sel) begin
      en_cnt = 0;
      setup_seen = 0;
      unstable = 0;
    end else if (!en) begin
      setup_seen = 1;
      cap_addr = addr;
      cap_wr = write;
      cap_data = wdata;
    end else begin
      en_cnt++;
      if (addr !== cap_addr || write !== cap_wr ||
          wdata !== cap_data)
        unstable = 1;
    end
    if (ready) begin
      lg_addr.push_back(addr);
      lg_wr.push_back(write);
      lg_data.push_back(write ? wdata : rdata);
      lg_en.push_back(en_cnt);
      lg_ok.push_back(setup_seen && !unstable);
      en_cnt = 0;
      setup_seen = 0;
      unstable = 0;
      if (!slv_err) begin
        if (write) begin
          if (addr == 3'd1) m_d0 <= wdata[15:0];
          if (addr == 3'd2) m_d1 <= wdata[15:0];
          if (addr == 3'd0) begin
            res_mem[res_wp[3:0]] <= alu_calc(wdata);
            res_wp <= res_wp + 1;
          end
        end else if (addr == 3'd4) begin
          if (full_used < full_req) full_used <= full_used + 1;
        end else if (addr == 3'd3 && res_wp != res_rp) begin
          res_rp <= res_rp + 1;
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    lg_addr.delete();
    lg_wr.delete();
    lg_data.delete();
    lg_en.delete();
    lg_ok.delete();
  endtask

  task automatic send_cmd(input logic [1:0] op,
                          input logic [7:0] id,
                          input logic [15:0] d0,
                          input logic [15:0] d1,
                          output bit ok);
    @(negedge clk);
    cmd_op = op;
    cmd_id = id;
    cmd_data0 = d0;
    cmd_data1 = d1;
    cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [15:0] res,
                         output logic fl,
                         output logic [7:0] id,
                         output logic er,
                         output bit ok);
    res = '0; fl = 0; id = '0; er = 0; ok = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (rsp_valid) begin
        res = rsp_result;
        fl = rsp_flag;
        id = rsp_id;
        er = rsp_err;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    bit          ok;
    bit          seen;
    int          cnt;
    logic [15:0] r;
    logic        f, e;
    logic [7:0]  id;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst sel", sel, 0);
    chk("rst en", en, 0);
    chk("rst write", write, 0);
    chk("rst addr", addr, 0);
    chk("rst wdata", wdata, 0);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst rsp", {rsp_valid, rsp_result, rsp_flag,
                    rsp_id, rsp_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle sel", sel, 0);

    // single add, zero wait states
    clear_log();
    send_cmd(2'd1, 8'h11, 16'h0005, 16'h0003, ok);
    chk("t1 accept", ok, 1);
    get_rsp(r, f, id, e, ok);
    chk("t1 rsp seen", ok, 1);
    chk("t1 rsp", {r, f, id, e}, {16'h0008, 1'b0, 8'h11, 1'b0});
    chk("t1 log n", lg_addr.size(), 6);
    chk("t1 chk", {lg_addr[0], lg_wr[0]}, {3'd4, 1'b0});
    chk("t1 d0", {lg_addr[1], lg_wr[1], lg_data[1]},
        {3'd1, 1'b1, 32'h5});
    chk("t1 d1", {lg_addr[2], lg_wr[2], lg_data[2]},
        {3'd2, 1'b1, 32'h3});
    chk("t1 ctrl", {lg_addr[3], lg_wr[3], lg_data[3]},
        {3'd0, 1'b1, 32'h1102});
    chk("t1 res rd", {lg_addr[5], lg_wr[5]}, {3'd3, 1'b0});

    // mul with three wait states per access
    clear_log();
    wait_cfg = 3;
    send_cmd(2'd2, 8'h22, 16'h000F, 16'h000F, ok);
    chk("t2 accept", ok, 1);
    get_rsp(r, f, id, e, ok);
    chk("t2 rsp seen", ok, 1);
    chk("t2 rsp", {r, f, id, e}, {16'h00E1, 1'b0, 8'h22, 1'b0});
    chk("t2 log n", lg_addr.size(), 6);
    cnt = 0;
    foreach (lg_en[i]) if (lg_en[i] != 4 || !lg_ok[i]) cnt++;
    chk("t2 en4 stable", cnt, 0);
    wait_cfg = 0;

    // input FIFO full for five status reads
    clear_log();
    full_req = full_used + 5;
    send_cmd(2'd1, 8'h44, 16'h0001, 16'h0002, ok);
    chk("t3 accept", ok, 1);
    @(negedge clk);
    cmd_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (cmd_ready) seen = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("t3 no 2nd accept", seen, 0);
    get_rsp(r, f, id, e, ok);
    chk("t3 rsp", {ok, r, f, id, e},
        {1'b1, 16'h0003, 1'b0, 8'h44, 1'b0});
    cnt = 0;
    foreach (lg_addr[i]) begin
      if (lg_wr[i] && lg_addr[i] == 3'd1) break;
      if (!lg_wr[i] && lg_addr[i] == 3'd4) cnt++;
    end
    chk("t3 status reads", cnt, 6);

    // slave error on the REG_1 write
    clear_log();
    err_on = 1'b1;
    send_cmd(2'd1, 8'h33, 16'h0010, 16'h0020, ok);
    chk("t4 accept", ok, 1);
    get_rsp(r, f, id, e, ok);
    err_on = 1'b0;
    chk("t4 rsp", {ok, r, f, id, e},
        {1'b1, 16'h0000, 1'b0, 8'h33, 1'b1});
    repeat (10) @(negedge clk);
    chk("t4 log n", lg_addr.size(), 3);
    chk("t4 last", {lg_addr[2], lg_wr[2]}, {3'd2, 1'b1});
    chk("t4 idle", sel, 0);

    // outstanding limit with results withheld
    clear_log();
    hold_results = 1'b1;
    send_cmd(2'd1, 8'h41, 16'hFFFF, 16'h0001, ok);
    chk("t5 accept a", ok, 1);
    send_cmd(2'd2, 8'h42, 16'h0010, 16'h0010, ok);
    chk("t5 accept b", ok, 1);
    @(negedge clk);
    cmd_op = 2'd1;
    cmd_id = 8'h43;
    cmd_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      #1 if (cmd_ready) seen = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("t5 limit", seen, 0);
    hold_results = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    chk("t5 rsp a seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("t5 hold", {rsp_valid, rsp_result, rsp_flag,
                    rsp_id, rsp_err},
        {1'b1, 16'h0000, 1'b1, 8'h41, 1'b0});
    get_rsp(r, f, id, e, ok);
    chk("t5 rsp a", {ok, r, f, id, e},
        {1'b1, 16'h0000, 1'b1, 8'h41, 1'b0});
    get_rsp(r, f, id, e, ok);
    chk("t5 rsp b", {ok, r, f, id, e},
        {1'b1, 16'h0100, 1'b0, 8'h42, 1'b0});

    // reset during an ACCESS phase
    wait_cfg = 3;
    send_cmd(2'd1, 8'h55, 16'h0001, 16'h0001, ok);
    chk("t6 accept", ok, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en) begin
        seen = 1;
        break;
      end
    end
    chk("t6 access", seen, 1);
    rst_n = 1'b0;
    #1;
    chk("t6 async drop", {sel, en}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cfg = 0;
    clear_log();
    repeat (6) @(negedge clk);
    chk("t6 quiet", {sel, lg_addr.size() == 0}, 2'b01);
    send_cmd(2'd1, 8'h66, 16'h0007, 16'h0009, ok);
    chk("t6 accept2", ok, 1);
    get_rsp(r, f, id, e, ok);
    chk("t6 rsp", {ok, r, f, id, e},
        {1'b1, 16'h0010, 1'b0, 8'h66, 1'b0});
    chk("t6 first xfer", {lg_addr[0], lg_wr[0], lg_ok[0],
                          lg_en[0] == 1},
        {3'd4, 1'b0, 1'b1, 1'b1});
    chk("t6 log n", lg_addr.size(), 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
